interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Sequences the four `hardInterrupt` lines into the CPU's interrupt mechanism. It synchronises the asynchronous lines, edge-detects them, and holds one pending bit per line. It applies a CPU-written mask and selects the highest-priority unmasked request. It then runs a request/acknowledge/return handshake with the CPU core and supplies a 20-bit vector address. It sits inside `IO`, between the external `hardInterrupt[3:0]` pins and the CPU's interrupt-entry and `iret` logic.

## Interface
- `VECTOR_BASE`, 20'h00100, vector address of line 0
- `VECTOR_STRIDE`, 20'h00010, address spacing between consecutive line vectors
- `clk`  in  1  system clock; all state on its rising edge
- `rstIn`  in  1  reset, asynchronous, active-low
- `hardInterrupt`  in  4  external interrupt lines, asynchronous, rising-edge triggered
- `intEnable`  in  1  CPU global interrupt-enable flag
- `maskWrite`  in  1  one-cycle strobe; loads `maskIn` into the mask register
- `maskIn`  in  4  mask value; bit=1 blocks the line
- `cpuAck`  in  1  CPU accepts the request (one-cycle pulse)
- `iretIn`  in  1  CPU executed `iret` (one-cycle pulse)
- `irq`  out  1  interrupt request to CPU
- `vectorOut`  out  20  handler address for the selected line
- `activeId`  out  2  selected / in-service line index
- `inService`  out  1  a handler is running
- `pendingOut`  out  4  raw pending bits (debug)

## Operation
- Input path, per line:
  - 2-flop synchroniser, then a third flop.
  - Rising edge = sync2 & ~sync3.
  - The edge sets `pending[i]`.
- Mask register:
  - Cleared to 4'b0000 (all enabled) on reset.
  - Loaded from `maskIn` when `maskWrite` is high.
  - Masking never clears pending; a masked pending line requests once it is unmasked.
- Eligible = pending & ~mask, and only when `intEnable`=1. Fixed priority: line 0 highest, line 3 lowest.
- FSM states IDLE, REQUEST, SERVICE:
  - IDLE -> REQUEST: any line eligible. Latch the winning index into `activeId`; `vectorOut` = `VECTOR_BASE` + `activeId`*`VECTOR_STRIDE` (20-bit wrap).
  - REQUEST: `irq`=1, and `activeId`/`vectorOut` stay frozen. Higher-priority arrivals do not preempt.
  - REQUEST -> SERVICE: on `cpuAck`. Clear `pending[activeId]`; `irq`=0, `inService`=1.
  - REQUEST -> IDLE: `intEnable` drops or `mask[activeId]` becomes 1 before ack. `irq`=0 and pending is retained.
  - SERVICE -> IDLE: on `iretIn`. `inService`=0.
- No nesting: new edges latch as pending during SERVICE and are serviced after `iret`.
- Ignored inputs: `cpuAck` outside REQUEST, and `iretIn` outside SERVICE.
- Simultaneous edge and clear on the same line in one cycle: set wins, so the pending bit remains 1.
- Repeated edges on an already-pending line collapse into one request.

## Timing
- Reset (`rstIn`=0, asynchronous, any state including mid-service):
  - `irq`=0, `vectorOut`=20'h00000, `activeId`=0, `inService`=0, `pendingOut`=0.
  - Mask=0, FSM=IDLE, all synchroniser flops=0.
- Edge-to-pending: a line going high before clk edge N sets `pending` at edge N+2 (visible on `pendingOut` after N+2).
- Pending-to-`irq`: `irq` rises at edge N+3 if eligible; `vectorOut`/`activeId` are valid in the same cycle.
- `cpuAck` sampled at edge M: `irq` low, `inService` high, and pending cleared, all after M.
- `iretIn` at edge K: `inService` low after K.
  - Another eligible line can raise `irq` at K+1, giving a minimum one IDLE cycle between services.
- `maskWrite` takes effect on eligibility in the cycle after the write edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then line 2 pulse high for 10 cycles -> `irq`=1 three edges after the rise; `activeId`=2, `vectorOut`=20'h00120; `cpuAck` -> `inService`=1, `pendingOut`=4'b0000; `iretIn` -> `inService`=0.
- Lines 3 and 1 rise in the same cycle -> first service `activeId`=1 (`vectorOut`=20'h00110); after `iretIn`, `irq` again with `activeId`=3 (20'h00130).
- `maskIn`=4'b0001 written, line 0 pulsed -> `pendingOut`=4'b0001 and `irq` stays 0; write `maskIn`=0 -> `irq`=1 next cycle with `activeId`=0.
- Line 0 rises while REQUEST holds `activeId`=3 -> `activeId` stays 3 until `cpuAck`; line 0 is serviced next after `iretIn`.
- `intEnable`=0 in REQUEST -> `irq`=0 next cycle and pending kept; `intEnable`=1 -> `irq` returns.
- `rstIn` low during SERVICE with lines pending -> all outputs 0 immediately (asynchronous); after release no `irq` until a new rising edge.

Source files
------------

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Synchronises and edge-detects four external interrupt lines,
//               holds pending bits, applies a mask, selects the highest
//               priority request and runs the irq/ack/iret handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller #(
    parameter logic [19:0] VECTOR_BASE   = 20'h00100,
    parameter logic [19:0] VECTOR_STRIDE = 20'h00010
) (
    input  logic        clk,
    input  logic        rstIn,
    input  logic [3:0]  hardInterrupt,
    input  logic        intEnable,
    input  logic        maskWrite,
    input  logic [3:0]  maskIn,
    input  logic        cpuAck,
    input  logic        iretIn,
    output logic        irq,
    output logic [19:0] vectorOut,
    output logic [1:0]  activeId,
    output logic        inService,
    output logic [3:0]  pendingOut
);

    localparam int c_LINES = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_irq;
    logic                w_irq_nxt;
    logic [19:0]         r_vector;
    logic [19:0]         w_vector_nxt;
    logic [1:0]          r_active;
    logic [1:0]          w_active_nxt;
    logic                r_in_service;
    logic                w_in_service_nxt;
    logic [c_LINES-1:0]  r_mask;
    logic [c_LINES-1:0]  w_pending;
    logic [c_LINES-1:0]  w_edge;
    logic [c_LINES-1:0]  w_clear;
    logic [c_LINES-1:0]  w_eligible;
    logic [1:0]          w_winner;
    logic [19:0]         w_winner_vector;

    // Per-line synchroniser, edge detector and pending bit; a set always
    // beats a clear arriving in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < c_LINES; gi++) begin : g_line
            logic r_sync1;
            logic r_sync2;
            logic r_sync3;
            logic r_pend;

            always_ff @(posedge clk or negedge rstIn) begin
                if (!rstIn) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_sync3 <= 1'b0;
                    r_pend  <= 1'b0;
                end else begin
                    r_sync1 <= hardInterrupt[gi];
                    r_sync2 <= r_sync1;
                    r_sync3 <= r_sync2;
                    r_pend  <= (r_pend & ~w_clear[gi]) | w_edge[gi];
                end
            end

            assign w_edge[gi]    = r_sync2 & ~r_sync3;
            assign w_pending[gi] = r_pend;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            r_mask <= '0;
        end else if (maskWrite) begin
            r_mask <= maskIn;
        end
    end

    assign w_eligible = intEnable ? (w_pending & ~r_mask) : '0;

    // Fixed priority: the lowest-numbered eligible line wins.
    always_comb begin
        w_winner = 2'd0;
        for (int i = c_LINES - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = 2'(i);
            end
        end
    end

    assign w_winner_vector = VECTOR_BASE + (VECTOR_STRIDE * {18'd0, w_winner});

    always_comb begin
        w_clear = '0;
        if ((r_state == ST_REQUEST) && cpuAck) begin
            w_clear[r_active] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            r_state      <= ST_IDLE;
            r_irq        <= 1'b0;
            r_vector     <= '0;
            r_active     <= '0;
            r_in_service <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_irq        <= w_irq_nxt;
            r_vector     <= w_vector_nxt;
            r_active     <= w_active_nxt;
            r_in_service <= w_in_service_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_irq_nxt        = r_irq;
        w_vector_nxt     = r_vector;
        w_active_nxt     = r_active;
        w_in_service_nxt = r_in_service;
        case (r_state)
            ST_IDLE: begin
                if (|w_eligible) begin
                    w_state_nxt  = ST_REQUEST;
                    w_irq_nxt    = 1'b1;
                    w_active_nxt = w_winner;
                    w_vector_nxt = w_winner_vector;
                end
            end
            ST_REQUEST: begin
                // Acknowledge takes precedence over a same-cycle withdrawal.
                if (cpuAck) begin
                    w_state_nxt      = ST_SERVICE;
                    w_irq_nxt        = 1'b0;
                    w_in_service_nxt = 1'b1;
                end else if (!intEnable || r_mask[r_active]) begin
                    w_state_nxt = ST_IDLE;
                    w_irq_nxt   = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (iretIn) begin
                    w_state_nxt      = ST_IDLE;
                    w_in_service_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_irq_nxt        = 1'b0;
                w_in_service_nxt = 1'b0;
            end
        endcase
    end

    assign irq        = r_irq;
    assign vectorOut  = r_vector;
    assign activeId   = r_active;
    assign inService  = r_in_service;
    assign pendingOut = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Directed scenarios plus randomized traffic for the interrupt
//               controller, checked against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rstIn = 1'b0;
    logic [3:0]  hardInterrupt = 4'b0;
    logic        intEnable = 1'b1;
    logic        maskWrite = 1'b0;
    logic [3:0]  maskIn = 4'b0;
    logic        cpuAck = 1'b0;
    logic        iretIn = 1'b0;
    logic        irq;
    logic [19:0] vectorOut;
    logic [1:0]  activeId;
    logic        inService;
    logic [3:0]  pendingOut;

    logic [27:0] obs;
    logic [27:0] exp;
    int vectors = 0;
    int errors  = 0;

    // Reference model: input sample history, pending set, mask, and the
    // controller mode (0 idle, 1 requesting, 2 handler running).
    logic [3:0]  m_h1, m_h2, m_h3;
    logic [3:0]  m_pend, m_mask;
    int          m_mode;
    logic [1:0]  m_id;
    logic [19:0] m_vec;

    interrupt_controller dut (
        .clk           (clk),
        .rstIn         (rstIn),
        .hardInterrupt (hardInterrupt),
        .intEnable     (intEnable),
        .maskWrite     (maskWrite),
        .maskIn        (maskIn),
        .cpuAck        (cpuAck),
        .iretIn        (iretIn),
        .irq           (irq),
        .vectorOut     (vectorOut),
        .activeId      (activeId),
        .inService     (inService),
        .pendingOut    (pendingOut)
    );

    always #5 clk = ~clk;

    assign obs = {irq, inService, activeId, vectorOut, pendingOut};

    task automatic model_reset();
        m_h1 = '0; m_h2 = '0; m_h3 = '0;
        m_pend = '0; m_mask = '0;
        m_mode = 0; m_id = '0; m_vec = '0;
    endtask

    // A line sampled high two edges ago but low three edges ago becomes
    // pending at this edge.
    task automatic model_step();
        logic [3:0] edges, elig, clr;
        int win;
        if (!rstIn) begin
            model_reset();
            return;
        end
        edges = m_h2 & ~m_h3;
        elig  = intEnable ? (m_pend & ~m_mask) : 4'b0;
        clr   = '0;
        win   = 0;
        case (m_mode)
            0: if (elig != 0) begin
                for (int i = 3; i >= 0; i--) if (elig[i]) win = i;
                m_mode = 1;
                m_id   = 2'(win);
                m_vec  = 20'h00100 + 20'h00010 * 20'(win);
            end
            1: if (cpuAck) begin
                clr[m_id] = 1'b1;
                m_mode = 2;
            end else if (!intEnable || m_mask[m_id]) begin
                m_mode = 0;
            end
            2: if (iretIn) m_mode = 0;
            default: m_mode = 0;
        endcase
        m_pend = (m_pend & ~clr) | edges;
        if (maskWrite) m_mask = maskIn;
        m_h3 = m_h2; m_h2 = m_h1; m_h1 = hardInterrupt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        exp = '0;
        vectors++; if (obs !== exp) begin errors++; $display("FAIL reset_async: got %h want %h", obs, exp); end
        tick(); tick();
        rstIn = 1'b1;
        tick();
        vectors++; if (obs !== exp) begin errors++; $display("FAIL reset_release: got %h want %h", obs, exp); end
    endtask

    task automatic test_single_line();
        hardInterrupt = 4'b0100;
        tick(); tick(); tick();
        exp = {1'b0, 1'b0, 2'd0, 20'h00000, 4'b0100};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL single_pending: got %h want %h", obs, exp); end
        tick();
        exp = {1'b1, 1'b0, 2'd2, 20'h00120, 4'b0100};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL single_irq: got %h want %h", obs, exp); end
        cpuAck = 1'b1; tick(); cpuAck = 1'b0;
        exp = {1'b0, 1'b1, 2'd2, 20'h00120, 4'b0000};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL single_ack: got %h want %h", obs, exp); end
        repeat (5) tick();
        hardInterrupt = 4'b0;
        vectors++; if (obs !== exp) begin errors++; $display("FAIL single_hold: got %h want %h", obs, exp); end
        iretIn = 1'b1; tick(); iretIn = 1'b0;
        exp = {1'b0, 1'b0, 2'd2, 20'h00120, 4'b0000};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL single_iret: got %h want %h", obs, exp); end
        repeat (3) tick();
    endtask

    task automatic test_simultaneous();
        hardInterrupt = 4'b1010;
        repeat (4) tick();
        exp = {1'b1, 1'b0, 2'd1, 20'h00110, 4'b1010};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL simul_first: got %h want %h", obs, exp); end
        cpuAck = 1'b1; tick(); cpuAck = 1'b0;
        iretIn = 1'b1; tick(); iretIn = 1'b0;
        exp = {1'b0, 1'b0, 2'd1, 20'h00110, 4'b1000};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL simul_gap: got %h want %h", obs, exp); end
        tick();
        exp = {1'b1, 1'b0, 2'd3, 20'h00130, 4'b1000};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL simul_second: got %h want %h", obs, exp); end
        cpuAck = 1'b1; tick(); cpuAck = 1'b0;
        hardInterrupt = 4'b0;
        iretIn = 1'b1; tick(); iretIn = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_mask();
        maskWrite = 1'b1; maskIn = 4'b0001; tick(); maskWrite = 1'b0;
        hardInterrupt = 4'b0001;
        repeat (4) tick();
        exp = {1'b0, 1'b0, 2'd3, 20'h00130, 4'b0001};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL mask_blocked: got %h want %h", obs, exp); end
        repeat (3) tick();
        vectors++; if (obs !== exp) begin errors++; $display("FAIL mask_still_blocked: got %h want %h", obs, exp); end
        maskWrite = 1'b1; maskIn = 4'b0000; tick(); maskWrite = 1'b0;
        vectors++; if (obs !== exp) begin errors++; $display("FAIL mask_write_edge: got %h want %h", obs, exp); end
        tick();
        exp = {1'b1, 1'b0, 2'd0, 20'h00100, 4'b0001};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL mask_release: got %h want %h", obs, exp); end
        cpuAck = 1'b1; tick(); cpuAck = 1'b0;
        hardInterrupt = 4'b0;
        iretIn = 1'b1; tick(); iretIn = 1'b0;
        tick();
    endtask

    task automatic test_no_preempt();
        hardInterrupt = 4'b1000;
        repeat (4) tick();
        exp = {1'b1, 1'b0, 2'd3, 20'h00130, 4'b1000};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL preempt_req3: got %h want %h", obs, exp); end
        hardInterrupt = 4'b1001;
        repeat (4) tick();
        exp = {1'b1, 1'b0, 2'd3, 20'h00130, 4'b1001};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL preempt_frozen: got %h want %h", obs, exp); end
        cpuAck = 1'b1; tick(); cpuAck = 1'b0;
        exp = {1'b0, 1'b1, 2'd3, 20'h00130, 4'b0001};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL preempt_ack: got %h want %h", obs, exp); end
        iretIn = 1'b1; tick(); iretIn = 1'b0;
        tick();
        exp = {1'b1, 1'b0, 2'd0, 20'h00100, 4'b0001};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL preempt_next: got %h want %h", obs, exp); end
        cpuAck = 1'b1; tick(); cpuAck = 1'b0;
        hardInterrupt = 4'b0;
        iretIn = 1'b1; tick(); iretIn = 1'b0;
        tick();
    endtask

    task automatic test_int_enable();
        hardInterrupt = 4'b0010;
        repeat (4) tick();
        intEnable = 1'b0; tick();
        exp = {1'b0, 1'b0, 2'd1, 20'h00110, 4'b0010};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL inten_drop: got %h want %h", obs, exp); end
        tick();
        vectors++; if (obs !== exp) begin errors++; $display("FAIL inten_hold: got %h want %h", obs, exp); end
        intEnable = 1'b1; tick();
        exp = {1'b1, 1'b0, 2'd1, 20'h00110, 4'b0010};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL inten_return: got %h want %h", obs, exp); end
        cpuAck = 1'b1; tick(); cpuAck = 1'b0;
        hardInterrupt = 4'b0;
        iretIn = 1'b1; tick(); iretIn = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_service();
        hardInterrupt = 4'b0010;
        repeat (4) tick();
        cpuAck = 1'b1; tick(); cpuAck = 1'b0;
        hardInterrupt = 4'b1010;
        repeat (3) tick();
        exp = {1'b0, 1'b1, 2'd1, 20'h00110, 4'b1000};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL rst_pre: got %h want %h", obs, exp); end
        #2;
        rstIn = 1'b0;
        #1;
        model_reset();
        exp = '0;
        vectors++; if (obs !== exp) begin errors++; $display("FAIL rst_async_mid: got %h want %h", obs, exp); end
        hardInterrupt = 4'b0;
        tick(); tick();
        rstIn = 1'b1;
        repeat (5) tick();
        vectors++; if (obs !== exp) begin errors++; $display("FAIL rst_quiet: got %h want %h", obs, exp); end
        hardInterrupt = 4'b0100;
        repeat (4) tick();
        exp = {1'b1, 1'b0, 2'd2, 20'h00120, 4'b0100};
        vectors++; if (obs !== exp) begin errors++; $display("FAIL rst_new_edge: got %h want %h", obs, exp); end
        cpuAck = 1'b1; tick(); cpuAck = 1'b0;
        hardInterrupt = 4'b0;
        iretIn = 1'b1; tick(); iretIn = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [3:0] lines;
        for (int n = 0; n < 1500; n++) begin
            lines = hardInterrupt;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) lines[i] = ~lines[i];
            end
            hardInterrupt = lines;
            intEnable = ($urandom_range(0, 9) != 0);
            cpuAck    = ($urandom_range(0, 2) == 0);
            iretIn    = ($urandom_range(0, 3) == 0);
            maskWrite = ($urandom_range(0, 15) == 0);
            maskIn    = 4'($urandom_range(0, 15));
            tick();
            exp = {(m_mode == 1), (m_mode == 2), m_id, m_vec, m_pend};
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_cycle %0d: got %h want %h", n, obs, exp);
            end
        end
        cpuAck = 1'b0; iretIn = 1'b0; maskWrite = 1'b0; intEnable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_simultaneous();
        test_mask();
        test_no_preempt();
        test_int_enable();
        test_reset_in_service();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
